flexbex_imem_responder: RTL and testbench

//  Instruction-memory responder (slave) for the Ibex instruction fetch port (req/gnt/rvalid/addr/rdata).

---
 rtl/flexbex_imem_pkg.sv | 16 +
 rtl/flexbex_imem_array.sv | 43 ++++
 rtl/flexbex_imem_responder.sv | 210 +++++++++++++++++++++
 tb/tb_flexbex_imem_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flexbex_imem_pkg.sv
// rtl/flexbex_imem_pkg.sv - shared widths and FSM state type for the instruction-memory responder
package flexbex_imem_pkg;

    localparam int WORD_W     = 32;
    localparam int WAIT_CNT_W = 4;

    // IDLE : no fetch in progress (at zero wait cycles the FSM never leaves IDLE)
    // STALL: counting wait cycles before the grant
    // GRANT: grant is given in this state unless the loader steals the cycle
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        GRANT = 2'd2
    } imem_state_t;

endpackage

// File: rtl/flexbex_imem_array.sv
// rtl/flexbex_imem_array.sv - DEPTH x 32 synchronous RAM, one write port, one registered read port
//
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write word index
//   i_wdata  write data
//   i_re     read enable; o_rdata updates on the next rising edge only when set
//   i_raddr  read word index
//   o_rdata  registered read data, holds between reads
//
// Contents and the read register have no reset so the array maps onto block RAM
// and the program survives a reset.
module flexbex_imem_array
    import flexbex_imem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/flexbex_imem_responder.sv
// rtl/flexbex_imem_responder.sv - Ibex instruction-fetch slave answering from a loadable local word array
//
// Fetch side (req/gnt/rvalid protocol, at most one outstanding request):
//   clk, resetn            rising-edge clock, asynchronous active-low reset
//   instr_req_i            fetch request
//   instr_addr_i           byte address, bits [1:0] ignored
//   instr_gnt_o            request accepted this cycle
//   instr_rvalid_o         one-cycle pulse the cycle after each grant
//   instr_rdata_o          fetched word, holds its value while rvalid is low
// Loader side:
//   load_start_i           clears the load pointer, wrap flag and checksum
//   load_strobe_i          writes load_data_i at the pointer and advances it; blocks grants
//   load_data_i            program word
//   load_ptr_o             next word index to be written
//   load_wrap_o            sticky, set when the pointer wraps from DEPTH-1 to 0
//   load_csum_o            running XOR of loaded words (only with IMEM_LOAD_CSUM_EN defined)
//
// Parameters: ADDR_W byte-address width, DEPTH = 2**(ADDR_W-2) words,
// WAIT_CYCLES (0..15) stall cycles inserted between request and grant.
// Optional feature macro: IMEM_LOAD_CSUM_EN.
module flexbex_imem_responder
    import flexbex_imem_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                instr_req_i,
    input  logic [ADDR_W-1:0]   instr_addr_i,
    output logic                instr_gnt_o,
    output logic                instr_rvalid_o,
    output logic [WORD_W-1:0]   instr_rdata_o,
    input  logic                load_start_i,
    input  logic                load_strobe_i,
    input  logic [WORD_W-1:0]   load_data_i,
    output logic [ADDR_W-3:0]   load_ptr_o,
    output logic                load_wrap_o
`ifdef IMEM_LOAD_CSUM_EN
    ,
    output logic [WORD_W-1:0]   load_csum_o
`endif
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
        WAIT_CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    imem_state_t           r_state;
    imem_state_t           w_state_nxt;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [WAIT_CNT_W-1:0] w_wait_cnt_nxt;
    logic                  w_gnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_gnt          = 1'b0;
        if (WAIT_CYCLES == 0) begin
            // Zero-wait build: grant straight through, loader wins the cycle.
            w_gnt = instr_req_i & ~load_strobe_i;
        end else begin
            unique case (r_state)
                IDLE: begin
                    // A loader cycle does not start the stall count.
                    if (instr_req_i && !load_strobe_i) begin
                        w_state_nxt    = STALL;
                        w_wait_cnt_nxt = '0;
                    end
                end
                STALL: begin
                    if (!instr_req_i) begin
                        w_state_nxt    = IDLE;
                        w_wait_cnt_nxt = '0;
                    end else if (!load_strobe_i) begin
                        if (r_wait_cnt == WAIT_LAST) begin
                            w_state_nxt    = GRANT;
                            w_wait_cnt_nxt = '0;
                        end else begin
                            w_wait_cnt_nxt = r_wait_cnt + WAIT_CNT_W'(1);
                        end
                    end
                end
                GRANT: begin
                    // Stay here while the loader owns the cycle so the grant
                    // is only delayed, never lost.
                    if (!instr_req_i) begin
                        w_state_nxt = IDLE;
                    end else if (!load_strobe_i) begin
                        w_gnt       = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt    = IDLE;
                    w_wait_cnt_nxt = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response: rvalid one cycle after grant, rdata straight from the RAM
    // read register (which only updates on a grant, so it holds by itself).
    // ------------------------------------------------------------------
    logic              r_rvalid;
    logic              r_rdata_seen;
    logic [WORD_W-1:0] w_ram_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rvalid     <= 1'b0;
            r_rdata_seen <= 1'b0;
        end else begin
            r_rvalid <= w_gnt;
            if (w_gnt) begin
                r_rdata_seen <= 1'b1;
            end
        end
    end

    // The RAM read register is not reset; mask it to zero until the first
    // grant after reset so rdata reads as zero out of reset.
    assign instr_gnt_o    = w_gnt;
    assign instr_rvalid_o = r_rvalid;
    assign instr_rdata_o  = r_rdata_seen ? w_ram_rdata : '0;

    // ------------------------------------------------------------------
    // Loader pointer and wrap flag
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] r_load_ptr;
    logic             r_load_wrap;
    logic [IDX_W-1:0] w_load_idx;

    // Start together with a strobe writes index 0.
    assign w_load_idx = load_start_i ? '0 : r_load_ptr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_load_ptr  <= '0;
            r_load_wrap <= 1'b0;
        end else begin
            if (load_start_i) begin
                r_load_ptr  <= '0;
                r_load_wrap <= 1'b0;
            end
            if (load_strobe_i) begin
                // DEPTH is a power of two, so the increment wraps naturally.
                r_load_ptr <= w_load_idx + IDX_W'(1);
                if (w_load_idx == LAST_IDX) begin
                    r_load_wrap <= 1'b1;
                end
            end
        end
    end

    assign load_ptr_o  = r_load_ptr;
    assign load_wrap_o = r_load_wrap;

`ifdef IMEM_LOAD_CSUM_EN
    logic [WORD_W-1:0] r_load_csum;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_load_csum <= '0;
        end else if (load_start_i || load_strobe_i) begin
            r_load_csum <= (load_start_i ? '0 : r_load_csum)
                         ^ (load_strobe_i ? load_data_i : '0);
        end
    end

    assign load_csum_o = r_load_csum;
`endif

    // Byte offset within the word is irrelevant to a word-wide fetch.
    logic w_unused_addr_lsb;
    assign w_unused_addr_lsb = ^instr_addr_i[1:0];

    // ------------------------------------------------------------------
    // Word array
    // ------------------------------------------------------------------
    flexbex_imem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .i_clk   (clk),
        .i_we    (load_strobe_i),
        .i_waddr (w_load_idx),
        .i_wdata (load_data_i),
        .i_re    (w_gnt),
        .i_raddr (instr_addr_i[ADDR_W-1:2]),
        .o_rdata (w_ram_rdata)
    );

endmodule

// File: tb/tb_flexbex_imem_responder.sv
// tb/tb_flexbex_imem_responder.sv - checks a zero-wait and a three-wait responder against a behavioural model
module tb_flexbex_imem_responder;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1024;
    localparam int IDX_W  = ADDR_W - 2;

    logic              clk    = 1'b0;
    logic              resetn = 1'b0;
    logic              req    = 1'b0;
    logic [ADDR_W-1:0] addr   = '0;
    logic              start  = 1'b0;
    logic              strobe = 1'b0;
    logic [31:0]       data   = '0;

    logic [1:0]        gnt;
    logic [1:0]        rvalid;
    logic [1:0]        wrap;
    logic [31:0]       rdata [2];
    logic [IDX_W-1:0]  ptr   [2];
`ifdef IMEM_LOAD_CSUM_EN
    logic [31:0]       csum  [2];
`endif

    always #5 clk = ~clk;

    flexbex_imem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_n0 (
        .clk(clk), .resetn(resetn),
        .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt[0]), .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]),
        .load_start_i(start), .load_strobe_i(strobe), .load_data_i(data),
        .load_ptr_o(ptr[0]), .load_wrap_o(wrap[0])
`ifdef IMEM_LOAD_CSUM_EN
        , .load_csum_o(csum[0])
`endif
    );

    flexbex_imem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(3)) u_n3 (
        .clk(clk), .resetn(resetn),
        .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt[1]), .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]),
        .load_start_i(start), .load_strobe_i(strobe), .load_data_i(data),
        .load_ptr_o(ptr[1]), .load_wrap_o(wrap[1])
`ifdef IMEM_LOAD_CSUM_EN
        , .load_csum_o(csum[1])
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    int          m_ptr   = 0;
    bit          m_wrap  = 0;
    logic [31:0] m_csum  = '0;
    int          m_age    [2];   // non-loader request cycles accumulated toward the grant
    bit          m_rvalid [2];
    logic [31:0] m_rdata  [2];
    bit          m_rknown [2];

    function automatic int nwait(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
        for (int d = 0; d < 2; d++) begin
            m_age[d] = 0; m_rvalid[d] = 0; m_rdata[d] = '0; m_rknown[d] = 1;
        end
    end

    always @(negedge clk) begin
        bit eg [2];
        int widx;
        if (!resetn) begin
            m_ptr = 0; m_wrap = 0; m_csum = '0;
            for (int d = 0; d < 2; d++) begin
                m_age[d] = 0; m_rvalid[d] = 0; m_rdata[d] = '0; m_rknown[d] = 1;
                chk($sformatf("rst_rvalid%0d", d), 32'(rvalid[d]), 32'(m_rvalid[d]));
                chk($sformatf("rst_rdata%0d", d), rdata[d], m_rdata[d]);
                chk($sformatf("rst_ptr%0d", d), 32'(ptr[d]), 32'(m_ptr));
                chk($sformatf("rst_wrap%0d", d), 32'(wrap[d]), 32'(m_wrap));
`ifdef IMEM_LOAD_CSUM_EN
                chk($sformatf("rst_csum%0d", d), csum[d], m_csum);
`endif
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!req || strobe) eg[d] = 0;
                else if (nwait(d) == 0) eg[d] = 1;
                else eg[d] = (m_age[d] == nwait(d) + 1);
                chk($sformatf("gnt%0d", d), 32'(gnt[d]), 32'(eg[d]));
                chk($sformatf("rvalid%0d", d), 32'(rvalid[d]), 32'(m_rvalid[d]));
                if (m_rknown[d]) chk($sformatf("rdata%0d", d), rdata[d], m_rdata[d]);
                chk($sformatf("ptr%0d", d), 32'(ptr[d]), 32'(m_ptr));
                chk($sformatf("wrap%0d", d), 32'(wrap[d]), 32'(m_wrap));
`ifdef IMEM_LOAD_CSUM_EN
                chk($sformatf("csum%0d", d), csum[d], m_csum);
`endif
            end
            // advance to the state after the coming rising edge
            for (int d = 0; d < 2; d++) begin
                m_rvalid[d] = eg[d];
                if (eg[d]) begin
                    m_rdata[d]  = m_mem[int'(addr[ADDR_W-1:2])];
                    m_rknown[d] = m_known[int'(addr[ADDR_W-1:2])];
                end
                if (!req) m_age[d] = 0;
                else if (strobe) m_age[d] = m_age[d];
                else if (eg[d]) m_age[d] = 0;
                else m_age[d] = m_age[d] + 1;
            end
            widx = start ? 0 : m_ptr;
            if (start) begin
                m_wrap = 0; m_csum = '0;
            end
            if (strobe) begin
                m_mem[widx]   = data;
                m_known[widx] = 1;
                m_csum        = m_csum ^ data;
                if (widx == DEPTH - 1) m_wrap = 1;
                m_ptr = (widx + 1) % DEPTH;
            end
            if (start && !strobe) m_ptr = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] prog [4];
    logic [31:0] last_word;

    initial begin
        prog[0] = 32'h0000_0013; prog[1] = 32'h0010_0093;
        prog[2] = 32'h0020_0113; prog[3] = 32'h0000_006F;

        cyc(); cyc();
        resetn = 1'b1;
        @(negedge clk);
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_ptr", 32'(ptr[0]), 32'h0);
        chk("reset_wrap", 32'(wrap), 32'h0);
        chk("reset_rdata", rdata[0], 32'h0);
        cyc();

        // load four program words
        for (int i = 0; i < 4; i++) begin
            strobe = 1'b1; data = prog[i];
            cyc();
        end
        strobe = 1'b0;
        @(negedge clk);
        chk("load_ptr_4", 32'(ptr[0]), 32'd4);
        cyc();

        // zero-wait back-to-back fetches
        req = 1'b1; addr = 12'h004;
        @(negedge clk); chk("n0_gnt_a", 32'(gnt[0]), 32'd1);
        cyc(); addr = 12'h008;
        @(negedge clk); chk("n0_gnt_b", 32'(gnt[0]), 32'd1);
        chk("n0_rdata_a", rdata[0], prog[1]); chk("n0_rv_a", 32'(rvalid[0]), 32'd1);
        cyc(); addr = 12'h00C;
        @(negedge clk); chk("n0_rdata_b", rdata[0], prog[2]); chk("n0_rv_b", 32'(rvalid[0]), 32'd1);
        cyc(); req = 1'b0;
        @(negedge clk); chk("n0_rdata_c", rdata[0], prog[3]); chk("n0_rv_c", 32'(rvalid[0]), 32'd1);
        cyc();
        @(negedge clk); chk("n0_rv_end", 32'(rvalid[0]), 32'd0);
        chk("n0_rdata_hold", rdata[0], prog[3]);
        cyc();

        // three-wait fetch, aligned then misaligned address
        for (int a = 0; a < 2; a++) begin
            req = 1'b1; addr = (a == 0) ? 12'h000 : 12'h002;
            for (int i = 0; i < 6; i++) begin
                if (i == 5) req = 1'b0;
                @(negedge clk);
                chk($sformatf("n3_gnt_c%0d", i), 32'(gnt[1]), (i == 4) ? 32'd1 : 32'd0);
                chk($sformatf("n3_rv_c%0d", i), 32'(rvalid[1]), (i == 5) ? 32'd1 : 32'd0);
                if (i == 5) chk("n3_rdata", rdata[1], 32'h0000_0013);
                cyc();
            end
        end

        // loader strobe coincident with a request
        req = 1'b1; addr = 12'h010; strobe = 1'b1; data = 32'hDEAD_BEEF;
        @(negedge clk); chk("coinc_gnt0", 32'(gnt[0]), 32'd0);
        cyc(); strobe = 1'b0;
        @(negedge clk); chk("coinc_gnt1", 32'(gnt[0]), 32'd1);
        cyc(); req = 1'b0;
        @(negedge clk); chk("coinc_rdata", rdata[0], 32'hDEAD_BEEF);
        chk("coinc_ptr", 32'(ptr[0]), 32'd5);
        cyc();

        // full fill with start on the first strobe, then one more to wrap
        for (int i = 0; i < DEPTH; i++) begin
            start = (i == 0); strobe = 1'b1; data = $urandom;
            cyc();
        end
        start = 1'b0; strobe = 1'b0;
        @(negedge clk);
        chk("fill_ptr", 32'(ptr[0]), 32'd0); chk("fill_wrap", 32'(wrap[0]), 32'd1);
        cyc();
        last_word = $urandom; strobe = 1'b1; data = last_word;
        cyc(); strobe = 1'b0;
        @(negedge clk);
        chk("wrap_ptr", 32'(ptr[0]), 32'd1); chk("wrap_flag", 32'(wrap[0]), 32'd1);
        cyc();
        req = 1'b1; addr = 12'h000;
        cyc(); req = 1'b0;
        @(negedge clk); chk("wrap_word0", rdata[0], last_word);
        cyc();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            req    = ($urandom_range(3) != 0);
            addr   = 12'($urandom);
            strobe = ($urandom_range(7) == 0);
            start  = ($urandom_range(63) == 0);
            data   = $urandom;
            cyc();
        end
        req = 1'b0; strobe = 1'b0; start = 1'b0;
        cyc(); cyc();

        // asynchronous reset with a response pending
        req = 1'b1; addr = 12'h008;
        cyc(); req = 1'b0;
        chk("pre_rst_rvalid", 32'(rvalid[0]), 32'd1);
        resetn = 1'b0;
        #1 chk("rst_async_rvalid", 32'(rvalid[0]), 32'd0);
        cyc(); resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("post_rst_rvalid", 32'(rvalid), 32'd0);
            cyc();
        end
        req = 1'b1; addr = 12'h008;
        cyc(); req = 1'b0;
        @(negedge clk);
        chk("post_rst_rv", 32'(rvalid[0]), 32'd1);
        chk("post_rst_read", rdata[0], m_mem[2]);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
